bitonic_uart_ctrl: RTL and testbench



---
 rtl/bitonic_uart_ctrl_if.sv | 29 ++
 rtl/bitonic_uart_ctrl.sv | 120 ++++++++++++
 tb/tb_bitonic_uart_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitonic_uart_ctrl_if.sv
// Bundle of the UART receive, sorter and UART transmit signals seen by the frame controller.
// The slave modport is the controller; the master modport is its surroundings.
interface bitonic_uart_ctrl_if #(
  parameter int N = 8,
  parameter int W = 8
);
  logic [W-1:0]   rx_data;
  logic           rx_valid;
  logic           rx_end;
  logic           sort_start;
  logic [N*W-1:0] sort_in;
  logic           sort_done;
  logic [N*W-1:0] sort_out;
  logic [W-1:0]   tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;
  logic           overrun;

  modport master (
    output rx_data, rx_valid, rx_end, sort_done, sort_out, tx_ready,
    input  sort_start, sort_in, tx_data, tx_valid, busy, overrun
  );

  modport slave (
    input  rx_data, rx_valid, rx_end, sort_done, sort_out, tx_ready,
    output sort_start, sort_in, tx_data, tx_valid, busy, overrun
  );
endinterface

// File: rtl/bitonic_uart_ctrl.sv
// Frame controller: gathers UART bytes up to an 0x03 marker or N entries, runs the bitonic
// sorter, then streams the valid sorted bytes plus a trailing 0x03 to the transmitter.
module bitonic_uart_ctrl #(
  parameter int           N   = 8,
  parameter int           W   = 8,
  parameter logic [W-1:0] PAD = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  bitonic_uart_ctrl_if.slave bus
);
  localparam int           IW     = $clog2(N);
  localparam int           CW     = $clog2(N) + 1;
  localparam logic [W-1:0] MARKER = 8'h03;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_idx;
  logic [W-1:0]   r_buf [N];
  logic [W-1:0]   r_res [N];
  logic [W-1:0]   r_tx_data;
  logic           r_tx_valid;
  logic           r_overrun;

  logic [CW-1:0]  w_next_idx;
  logic           w_tx_fire;
  logic [N*W-1:0] w_sort_in;

  assign w_next_idx = r_idx + 1'b1;
  assign w_tx_fire  = r_tx_valid && bus.tx_ready;

  // NOTE: always_comb outputs get a full default before the loop so no latch can be inferred.
  always_comb begin
    w_sort_in = '0;
    for (int i = 0; i < N; i++) begin
      w_sort_in[i*W +: W] = r_buf[i];
    end
  end

  // NOTE: all state registers update with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_count    <= '0;
      r_idx      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      // NOTE: these arrays are reset on purpose; unsent slots must read as PAD from the first frame on.
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= PAD;
        r_res[i] <= '0;
      end
    end else begin
      // Any byte arriving outside LOAD is dropped and flagged one cycle later.
      r_overrun <= bus.rx_valid && (r_state != S_LOAD);

      case (r_state)
        S_LOAD: begin
          if (bus.rx_valid) begin
            if (bus.rx_end) begin
              if (r_count != '0) r_state <= S_START;
            end else if (r_count < CW'(N)) begin
              r_buf[r_count[IW-1:0]] <= bus.rx_data;
              r_count                <= r_count + 1'b1;
              if (r_count == CW'(N - 1)) r_state <= S_START;
            end
          end
        end

        S_START: r_state <= S_WAIT;

        S_WAIT: begin
          if (bus.sort_done) begin
            for (int i = 0; i < N; i++) begin
              r_res[i] <= bus.sort_out[i*W +: W];
            end
            r_idx      <= '0;
            r_tx_data  <= bus.sort_out[W-1:0];
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND;
          end
        end

        S_SEND: begin
          if (w_tx_fire) begin
            // r_idx == r_count means the terminator is the byte just accepted.
            if (r_idx == r_count) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= '0;
              r_count    <= '0;
              r_idx      <= '0;
              r_state    <= S_LOAD;
              for (int i = 0; i < N; i++) begin
                r_buf[i] <= PAD;
              end
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= (w_next_idx == r_count) ? MARKER : r_res[w_next_idx[IW-1:0]];
            end
          end
        end

        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.sort_start = (r_state == S_START);
  assign bus.sort_in    = w_sort_in;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.busy       = (r_state != S_LOAD);
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_bitonic_uart_ctrl.sv
// Bench for bitonic_uart_ctrl: behavioural sorter, expected-byte queue for the transmit side,
// and one task per scenario.
module tb_bitonic_uart_ctrl;
  localparam int N = 8;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitonic_uart_ctrl_if #(.N(N), .W(W)) bus ();

  bitonic_uart_ctrl #(.N(N), .W(W), .PAD(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int             tests_run    = 0;
  int             tests_failed = 0;
  logic [7:0]     exp_q[$];
  int             accept_cnt   = 0;
  int             sorter_delay = 3;
  int             sorter_cnt   = 0;
  logic [N*W-1:0] sorter_cap;
  bit             done_pulse   = 1'b0;
  bit             prev_stall   = 1'b0;
  logic [7:0]     prev_data;

  function automatic logic [N*W-1:0] sort_vec(input logic [N*W-1:0] v);
    logic [W-1:0] a [N];
    logic [W-1:0] t;
    for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
    for (int i = 0; i < N - 1; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    sort_vec = '0;
    for (int i = 0; i < N; i++) sort_vec[i*W +: W] = a[i];
  endfunction

  // Expected transmit stream: stimulus bytes in ascending order, then the 0x03 terminator.
  task automatic push_expected(input logic [7:0] f[$]);
    logic [7:0] s[$];
    logic [7:0] t;
    s = f;
    for (int i = 0; i < s.size(); i++)
      for (int j = 0; j < s.size() - 1 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    foreach (s[k]) exp_q.push_back(s[k]);
    exp_q.push_back(8'h03);
  endtask

  // Transmit monitor: samples just before the edge that would accept the offered byte.
  always @(negedge clk) begin : tx_monitor
    logic [7:0] e;
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests_run++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin
          tests_failed++;
          $display("FAIL tx_hold: got valid=%b data=%h, required valid=1 data=%h",
                   bus.tx_valid, bus.tx_data, prev_data);
        end
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL tx_unexpected: got %h, required no byte", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.tx_data !== e) begin
            tests_failed++;
            $display("FAIL tx_byte: got %h, required %h", bus.tx_data, e);
          end
        end
        accept_cnt++;
      end
      prev_stall = (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1);
      prev_data  = bus.tx_data;
    end
  end

  // Behavioural sorter: captures sort_in on sort_start, answers after sorter_delay cycles.
  always @(negedge clk) begin
    if (done_pulse) begin
      bus.sort_done = 1'b0;
      done_pulse    = 1'b0;
      tests_run++;
      if (bus.tx_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL tx_valid_rise: got %b, required 1 in cycle after sort_done", bus.tx_valid);
      end
    end
    if (sorter_cnt > 0) begin
      sorter_cnt--;
      if (sorter_cnt == 0) begin
        tests_run++;
        if (bus.sort_in !== sorter_cap) begin
          tests_failed++;
          $display("FAIL sort_in_stable: got %h, required %h", bus.sort_in, sorter_cap);
        end
        bus.sort_out  = sort_vec(sorter_cap);
        bus.sort_done = 1'b1;
        done_pulse    = 1'b1;
      end
    end
    if (bus.sort_start === 1'b1) begin
      sorter_cap = bus.sort_in;
      sorter_cnt = sorter_delay;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit is_end);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.rx_end   = is_end;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_end   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk); #3;
      if (exp_q.size() == 0 && bus.tx_valid === 1'b0) done = 1'b1;
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_accepts(input int target, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk); #1;
      if (accept_cnt >= target) done = 1'b1;
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s_accepts: got %0d, required %0d", name, accept_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.rx_end = 1'b0;
    bus.sort_done = 1'b0; bus.sort_out = '0; bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run += 6;
    if (bus.tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_tx_valid: got %b, required 0", bus.tx_valid); end
    if (bus.tx_data !== 8'h00) begin tests_failed++; $display("FAIL rst_tx_data: got %h, required 00", bus.tx_data); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
    if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL rst_overrun: got %b, required 0", bus.overrun); end
    if (bus.sort_start !== 1'b0) begin tests_failed++; $display("FAIL rst_sort_start: got %b, required 0", bus.sort_start); end
    if (bus.sort_in !== {N{8'hFF}}) begin tests_failed++; $display("FAIL rst_sort_in: got %h, required all FF", bus.sort_in); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] f[$];
    f = {8'h05, 8'h01, 8'h04, 8'h02};
    push_expected(f);
    foreach (f[k]) send_byte(f[k], 1'b0);
    tests_run++;
    if (bus.sort_start !== 1'b0) begin tests_failed++; $display("FAIL basic_early_start: got %b, required 0", bus.sort_start); end
    send_byte(8'h03, 1'b1);
    tests_run += 3;
    if (bus.sort_start !== 1'b1) begin tests_failed++; $display("FAIL basic_start: got %b, required 1", bus.sort_start); end
    if (bus.sort_in !== 64'hFFFF_FFFF_0204_0105) begin tests_failed++; $display("FAIL basic_sort_in: got %h, required ffffffff02040105", bus.sort_in); end
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %b, required 1", bus.busy); end
    @(negedge clk);
    tests_run++;
    if (bus.sort_start !== 1'b0) begin tests_failed++; $display("FAIL basic_start_width: got %b, required 0", bus.sort_start); end
    wait_drain("basic");
    tests_run += 2;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL basic_idle_busy: got %b, required 0", bus.busy); end
    if (bus.sort_in !== {N{8'hFF}}) begin tests_failed++; $display("FAIL basic_refill: got %h, required all FF", bus.sort_in); end
  endtask

  task automatic test_full_frame();
    logic [7:0] f[$];
    f = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03 + 8'h00, 8'h02, 8'h01};
    // 0x03 cannot be data; replace it with 0x09 so the frame stays eight distinct bytes.
    f[5] = 8'h09;
    push_expected(f);
    for (int k = 0; k < N; k++) begin
      send_byte(f[k], 1'b0);
      if (k == N - 2) begin
        tests_run++;
        if (bus.sort_start !== 1'b0) begin tests_failed++; $display("FAIL full_early_start: got %b, required 0", bus.sort_start); end
      end
    end
    tests_run++;
    if (bus.sort_start !== 1'b1) begin tests_failed++; $display("FAIL full_start: got %b, required 1", bus.sort_start); end
    send_byte(8'h03, 1'b1);
    tests_run++;
    if (bus.overrun !== 1'b1) begin tests_failed++; $display("FAIL full_late_marker_overrun: got %b, required 1", bus.overrun); end
    @(negedge clk);
    tests_run++;
    if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL full_overrun_width: got %b, required 0", bus.overrun); end
    wait_drain("full");
  endtask

  task automatic test_empty_marker();
    send_byte(8'h03, 1'b1);
    tests_run += 3;
    if (bus.sort_start !== 1'b0) begin tests_failed++; $display("FAIL empty_start: got %b, required 0", bus.sort_start); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL empty_busy: got %b, required 0", bus.busy); end
    if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL empty_overrun: got %b, required 0", bus.overrun); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.sort_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_stay_load: got busy=%b start=%b, required 0 0", bus.busy, bus.sort_start);
    end
  endtask

  task automatic test_spurious_done();
    bus.sort_out  = 64'h0102_0304_0506_0708;
    bus.sort_done = 1'b1;
    @(negedge clk);
    bus.sort_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL spurious_done: got tx_valid=%b busy=%b, required 0 0", bus.tx_valid, bus.busy);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [7:0] f[$];
    int base;
    f = {8'h30, 8'h10, 8'h20};
    base = accept_cnt;
    push_expected(f);
    foreach (f[k]) send_byte(f[k], 1'b0);
    send_byte(8'h03, 1'b1);
    wait_accepts(base + 1, "stall");
    bus.tx_ready = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      tests_run++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h20) begin
        tests_failed++;
        $display("FAIL stall_hold: got valid=%b data=%h, required 1 20", bus.tx_valid, bus.tx_data);
      end
    end
    bus.tx_ready = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_wait_overrun();
    logic [7:0] f[$];
    f = {8'h44, 8'h22, 8'h33};
    sorter_delay = 12;
    push_expected(f);
    foreach (f[k]) send_byte(f[k], 1'b0);
    send_byte(8'h03, 1'b1);
    @(negedge clk);
    repeat (3) begin
      send_byte(8'h55, 1'b0);
      tests_run++;
      if (bus.overrun !== 1'b1) begin tests_failed++; $display("FAIL wait_overrun: got %b, required 1", bus.overrun); end
      @(negedge clk);
      tests_run++;
      if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL wait_overrun_width: got %b, required 0", bus.overrun); end
    end
    wait_drain("wait_overrun");
    sorter_delay = 3;
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] f[$];
    int base;
    f = {8'h40, 8'h10, 8'h30, 8'h20};
    base = accept_cnt;
    push_expected(f);
    foreach (f[k]) send_byte(f[k], 1'b0);
    send_byte(8'h03, 1'b1);
    wait_accepts(base + 2, "midrst");
    rst = 1'b1;
    exp_q.delete();
    #1;
    tests_run += 3;
    if (bus.tx_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_tx_valid: got %b, required 0", bus.tx_valid); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b, required 0", bus.busy); end
    if (bus.tx_data !== 8'h00) begin tests_failed++; $display("FAIL midrst_tx_data: got %h, required 00", bus.tx_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    f = {8'h07, 8'h09, 8'h06};
    push_expected(f);
    foreach (f[k]) send_byte(f[k], 1'b0);
    send_byte(8'h03, 1'b1);
    tests_run++;
    if (bus.sort_in !== 64'hFFFF_FFFF_FF06_0907) begin tests_failed++; $display("FAIL midrst_sort_in: got %h, required ffffffffff060907", bus.sort_in); end
    wait_drain("midrst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_full_frame();
    test_empty_marker();
    test_spurious_done();
    test_back_to_back_stall();
    test_wait_overrun();
    test_reset_mid_send();
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL leftover: got %0d queued bytes, required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
